uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver paired with uart_tx on the 3.125 MHz clock domain.
- Deserialises 11-bit frames: start(0), 8 data bits MSB-first, parity, stop(1). Each bit lasts 14 clocks.
- Presents the received byte, the parity bit and error flags, with a one-cycle completion strobe, to downstream control logic.

Parameters:
- CLKS_PER_BIT, 14, clocks per serial bit.
- DATA_BITS, 8, payload width.
- SAMPLE_POINT, 7, counter value (0..13) at which the bit is sampled.

Ports:
- clk_3125  in  1  3.125 MHz system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx  in  1  serial line, idle high.
- parity_type  in  1  0 = even, 1 = odd.
- rx_msg  out  8  last received byte, bit 7 = first data bit on the line.
- rx_parity  out  1  parity bit as received.
- rx_complete  out  1  one-cycle strobe at the end of the stop bit.
- parity_err  out  1  parity mismatch for the last frame.
- frame_err  out  1  stop bit sampled 0 for the last frame.

Behaviour:
- Reset (async, immediate):
  - rx_msg=0, rx_parity=0, rx_complete=0, parity_err=0, frame_err=0.
  - FSM goes to IDLE; counters cleared; synchroniser flops set to 1.
- rx passes through a fixed 2-flop synchroniser (rx_s); the FSM uses rx_s only.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s==0, go to START with bit_cnt=0 (clock counter 0..CLKS_PER_BIT-1).
  - START: at SAMPLE_POINT, if rx_s==1 the start is false, return to IDLE, outputs untouched. At counter 13, go to DATA.
  - DATA: sample at SAMPLE_POINT and shift into the shift register from the LSB side, so the first bit ends in bit 7. After 8 bits, at counter 13, go to PARITY.
  - PARITY: sample at SAMPLE_POINT into the parity register. At counter 13, go to STOP.
  - STOP: sample at SAMPLE_POINT. At counter 13, update all outputs together, assert rx_complete, go to IDLE.
- Output update at the end of STOP:
  - rx_msg <= shift register; rx_parity <= received parity bit.
  - Even parity: expected bit = ^rx_msg. Odd parity: expected bit = ~^rx_msg. parity_err <= (received != expected).
  - frame_err <= ~stop sample.
- rx_msg and the flags hold until the next completed frame. A false start or reset mid-frame leaves previous values, except that reset clears them.
- rx_complete is high for exactly one clock.
- Timing: let E0 be the first rising edge at which rx is sampled 0. rx_complete is high from edge E0+155 to edge E0+156, i.e. 154 frame clocks plus 2 synchroniser clocks, minus 1.
- Back-to-back frames:
  - A new start may begin on the clock after the STOP→IDLE transition.
  - Zero idle gap and the 1-clock gap produced by uart_tx are both supported.
- A frame with frame_err still updates rx_msg and still pulses rx_complete.
- parity_type is sampled at the end of STOP. Changing it mid-frame is legal; only the value at the end of STOP matters.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rx_s at counters 6, 7 and 8. The bit is committed at counter 8. The START false-start check uses the majority result. All timing is otherwise unchanged.
- Undefined: single sample at SAMPLE_POINT.

Decomposition:
- Package uart_pkg holds:
  - the state typedef (IDLE, START, DATA, PARITY, STOP);
  - CLKS_PER_BIT, DATA_BITS, SAMPLE_POINT defaults;
  - PARITY_EVEN=0, PARITY_ODD=1.
- uart_tx should import the same package.
- One sub-module: uart_rx_sampler, containing the synchroniser, the bit-clock counter and the sample/majority logic. It outputs a sample strobe plus the bit value and an end_of_bit strobe.

Test Plan:
- Even parity, 0xA5, line bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> rx_msg=8'hA5, rx_parity=0, parity_err=0, frame_err=0, single rx_complete pulse at E0+155.
- Odd parity, 0x01, parity bit 0 -> rx_msg=8'h01, parity_err=0. The same frame with parity bit 1 -> parity_err=1, rx_complete still pulses.
- Even parity, 0x3C with stop bit forced 0 -> rx_msg=8'h3C, frame_err=1, parity_err=0.
- 4-clock low glitch on the idle line -> no rx_complete, outputs unchanged, FSM back in IDLE before the next frame; next frame 0x5A is received correctly.
- Ten back-to-back frames from uart_tx with a 1-clock gap -> ten rx_complete pulses, bytes match in order, zero errors.
- rst pulsed during DATA of 0xFF -> outputs cleared immediately, no rx_complete. A following clean 0x81 frame -> rx_msg=8'h81.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and frame constants for uart_rx / uart_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   c_clks_per_bit = 14;
  localparam int   c_data_bits    = 8;
  localparam int   c_sample_point = 7;

  localparam logic c_parity_even  = 1'b0;
  localparam logic c_parity_odd   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : rx synchroniser, bit-clock counter and bit sampling. With
//            UART_RX_MAJORITY_EN defined, each bit is a 2-of-3 vote.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit,
  parameter int SAMPLE_POINT = c_sample_point
) (
  input  logic clk_3125,
  input  logic rst,
  input  logic i_rx,
  input  logic i_idle,
  output logic o_rx_s,
  output logic o_sample_stb,
  output logic o_bit,
  output logic o_end_of_bit
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_last = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_mid  = CW'(SAMPLE_POINT);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // The idle cycle that first sees rx_s low is counter 0 of the start bit.
  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_idle) begin
      r_cnt <= r_sync2 ? '0 : CW'(1);
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_rx_s       = r_sync2;
  assign o_end_of_bit = ~i_idle & (r_cnt == c_last);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] c_early = CW'(SAMPLE_POINT - 1);
  localparam logic [CW-1:0] c_late  = CW'(SAMPLE_POINT + 1);

  logic r_s_early;
  logic r_s_mid;

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_s_early <= 1'b1;
      r_s_mid   <= 1'b1;
    end else begin
      if (r_cnt == c_early) r_s_early <= r_sync2;
      if (r_cnt == c_mid)   r_s_mid   <= r_sync2;
    end
  end

  assign o_sample_stb = ~i_idle & (r_cnt == c_late);
  assign o_bit        = (r_s_early & r_s_mid) | (r_s_early & r_sync2) | (r_s_mid & r_sync2);
`else
  assign o_sample_stb = ~i_idle & (r_cnt == c_mid);
  assign o_bit        = r_sync2;
`endif

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 11-bit frame receiver (start, 8 data MSB-first, parity, stop).
//            Optional majority-vote sampling via UART_RX_MAJORITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = c_clks_per_bit,
  parameter int DATA_BITS    = c_data_bits,
  parameter int SAMPLE_POINT = c_sample_point
) (
  input  logic                 clk_3125,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 parity_type,
  output logic [DATA_BITS-1:0] rx_msg,
  output logic                 rx_parity,
  output logic                 rx_complete,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int             DW          = $clog2(DATA_BITS);
  localparam logic [DW-1:0]  c_last_data = DW'(DATA_BITS - 1);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [DW-1:0]        r_data_cnt;
  logic                 r_parity;
  logic                 r_stop;

  logic w_idle;
  logic w_rx_s;
  logic w_sample_stb;
  logic w_bit;
  logic w_end_of_bit;
  logic w_exp_par;

  assign w_idle    = (r_state == IDLE);
  assign w_exp_par = (parity_type == c_parity_odd) ? ~^r_shift : ^r_shift;

  uart_rx_sampler #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_sampler (
    .clk_3125     (clk_3125),
    .rst          (rst),
    .i_rx         (rx),
    .i_idle       (w_idle),
    .o_rx_s       (w_rx_s),
    .o_sample_stb (w_sample_stb),
    .o_bit        (w_bit),
    .o_end_of_bit (w_end_of_bit)
  );

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_data_cnt  <= '0;
      r_parity    <= 1'b0;
      r_stop      <= 1'b1;
      rx_msg      <= '0;
      rx_parity   <= 1'b0;
      rx_complete <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_complete <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state    <= START;
            r_data_cnt <= '0;
          end
        end
        START: begin
          if (w_sample_stb && w_bit) r_state <= IDLE;
          else if (w_end_of_bit)     r_state <= DATA;
        end
        DATA: begin
          if (w_sample_stb) r_shift <= {r_shift[DATA_BITS-2:0], w_bit};
          if (w_end_of_bit) begin
            if (r_data_cnt == c_last_data) begin
              r_state    <= PARITY;
              r_data_cnt <= '0;
            end else begin
              r_data_cnt <= r_data_cnt + DW'(1);
            end
          end
        end
        PARITY: begin
          if (w_sample_stb) r_parity <= w_bit;
          if (w_end_of_bit) r_state  <= STOP;
        end
        STOP: begin
          if (w_sample_stb) r_stop <= w_bit;
          // All results publish together, with parity_type taken right here.
          if (w_end_of_bit) begin
            rx_msg      <= r_shift;
            rx_parity   <= r_parity;
            parity_err  <= r_parity ^ w_exp_par;
            frame_err   <= ~r_stop;
            rx_complete <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx with a frame-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

  typedef struct {
    int         cyc;
    logic [7:0] msg;
    logic       par;
    logic       perr;
    logic       ferr;
  } rec_t;

  logic       clk_3125 = 1'b0;
  logic       rst;
  logic       rx;
  logic       parity_type;
  logic [7:0] rx_msg;
  logic       rx_parity;
  logic       rx_complete;
  logic       parity_err;
  logic       frame_err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t got_q[$];
  rec_t last_exp;

  uart_rx dut (
    .clk_3125    (clk_3125),
    .rst         (rst),
    .rx          (rx),
    .parity_type (parity_type),
    .rx_msg      (rx_msg),
    .rx_parity   (rx_parity),
    .rx_complete (rx_complete),
    .parity_err  (parity_err),
    .frame_err   (frame_err)
  );

  always #5 clk_3125 = ~clk_3125;

  always @(posedge clk_3125) cyc++;

  always @(negedge clk_3125) begin
    if (rx_complete !== 1'b0) begin
      rec_t r;
      r.cyc  = cyc;
      r.msg  = rx_msg;
      r.par  = rx_parity;
      r.perr = parity_err;
      r.ferr = frame_err;
      got_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one frame, 14 clocks per bit; nbits < 11 truncates it (no result expected).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input logic pt, input int gap, input int nbits);
    logic [10:0] fr;
    int          e0;
    fr = {1'b0, d, p, s};
    e0 = cyc + 1;
    for (int i = 0; i < nbits; i++) begin
      if (i == 2) parity_type = 1'($urandom);
      if (i == 9) parity_type = pt;
      rx = fr[10-i];
      repeat (14) @(negedge clk_3125);
    end
    if (nbits == 11) begin
      rec_t r;
      int   ones_odd;
      logic exp_bit;
      ones_odd = $countones(d) % 2;
      exp_bit  = pt ? logic'(1 - ones_odd) : logic'(ones_odd);
      r.cyc  = e0 + 155;
      r.msg  = d;
      r.par  = p;
      r.perr = (p != exp_bit);
      r.ferr = ~s;
      exp_q.push_back(r);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk_3125);
  endtask

  task automatic drain(input string tag);
    int guard;
    int n;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 4000) begin
      @(negedge clk_3125);
      guard++;
    end
    repeat (20) @(negedge clk_3125);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d]_cycle", tag, i), got_q[i].cyc,  exp_q[i].cyc);
      chk($sformatf("%s[%0d]_msg",   tag, i), got_q[i].msg,  exp_q[i].msg);
      chk($sformatf("%s[%0d]_par",   tag, i), got_q[i].par,  exp_q[i].par);
      chk($sformatf("%s[%0d]_perr",  tag, i), got_q[i].perr, exp_q[i].perr);
      chk($sformatf("%s[%0d]_ferr",  tag, i), got_q[i].ferr, exp_q[i].ferr);
    end
    if (exp_q.size() > 0) last_exp = exp_q[exp_q.size()-1];
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_msg"},  rx_msg,     last_exp.msg);
    chk({tag, "_par"},  rx_parity,  last_exp.par);
    chk({tag, "_perr"}, parity_err, last_exp.perr);
    chk({tag, "_ferr"}, frame_err,  last_exp.ferr);
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       pt;
    int         ones_odd;

    rst         = 1'b1;
    rx          = 1'b1;
    parity_type = 1'b0;
    last_exp    = '{cyc: 0, msg: 8'h00, par: 1'b0, perr: 1'b0, ferr: 1'b0};
    repeat (3) @(negedge clk_3125);
    chk_held("reset");
    chk("reset_complete", rx_complete, 1'b0);
    rst = 1'b0;
    repeat (5) @(negedge clk_3125);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 10, 11);
    drain("even_a5");

    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 10, 11);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 10, 11);
    drain("odd_01");

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 10, 11);
    drain("stop0_3c");

    rx = 1'b0;
    repeat (4) @(negedge clk_3125);
    rx = 1'b1;
    repeat (200) @(negedge clk_3125);
    chk("glitch_count", got_q.size(), 0);
    chk_held("glitch_hold");
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 10, 11);
    drain("after_glitch");

    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      pt = 1'($urandom);
      ones_odd = $countones(d) % 2;
      p  = pt ? logic'(1 - ones_odd) : logic'(ones_odd);
      send_frame(d, p, 1'b1, pt, 1, 11);
    end
    drain("b2b");

    send_frame(8'hFF, 1'b0, 1'b1, 1'b0, 0, 5);
    rst = 1'b1;
    #1;
    last_exp = '{cyc: 0, msg: 8'h00, par: 1'b0, perr: 1'b0, ferr: 1'b0};
    chk_held("midreset");
    @(negedge clk_3125);
    rst = 1'b0;
    repeat (200) @(negedge clk_3125);
    chk("midreset_count", got_q.size(), 0);
    chk_held("midreset_hold");
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 10, 11);
    drain("after_reset");

    for (int i = 0; i < 20; i++) begin
      d  = 8'($urandom);
      p  = 1'($urandom);
      s  = ($urandom_range(0, 5) != 0);
      pt = 1'($urandom);
      send_frame(d, p, s, pt, $urandom_range(0, 3), 11);
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
